// File: rtl/send_board_if.sv
// Handshake and data bundle between the game controller, send_board and the UART transmitter.
// The slave modport is the send_board view; the master modport is the controller/UART view.
interface send_board_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  localparam int CELLS = ROWS * COLS;

  logic             req;
  logic             target_a;
  logic [CELLS-1:0] board_a;
  logic [CELLS-1:0] board_b;
  logic             ready;
  logic             done;
  logic             uart_wr;
  logic [7:0]       uart_d;
  logic             uart_ready;

  modport slave (
    input  req,
    input  target_a,
    input  board_a,
    input  board_b,
    input  uart_ready,
    output ready,
    output done,
    output uart_wr,
    output uart_d
  );

  modport master (
    output req,
    output target_a,
    output board_a,
    output board_b,
    output uart_ready,
    input  ready,
    input  done,
    input  uart_wr,
    input  uart_d
  );
endinterface

// File: rtl/send_board.sv
// Serializes a latched two-player board snapshot as ASCII rows plus a turn prompt
// onto the UART byte interface, one strobe every other cycle at most.
module send_board #(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic         clk,
  input  logic         reset,
  send_board_if.slave  bus
);

  localparam int CELLS = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CELL   = 3'd1,
    S_CR     = 3'd2,
    S_LF     = 3'd3,
    S_TURN   = 3'd4,
    S_PROMPT = 3'd5,
    S_GAP    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CELLS-1:0] a_q, a_d;
  logic [CELLS-1:0] b_q, b_d;
  logic             tgt_q, tgt_d;
  logic             busy_q, busy_d;
  logic             wr_q, wr_d;
  logic [7:0]       dat_q, dat_d;
  logic             done_q, done_d;

  logic             emit_s;
  logic [7:0]       char_s;
  state_t           next_s;
  logic [ROW_W-1:0] row_nx_s;
  logic [COL_W-1:0] col_nx_s;
  logic [IDX_W-1:0] idx_s;

  // A cell claimed by both players can only come from a corrupt board, so flag it visibly.
  function automatic logic [7:0] cell_char(input logic a, input logic b);
    logic [7:0] ch;
    case ({a, b})
      2'b10:   ch = 8'h58;
      2'b01:   ch = 8'h4F;
      2'b00:   ch = 8'h2E;
      2'b11:   ch = 8'h23;
      default: ch = 8'h23;
    endcase
    return ch;
  endfunction

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    row_d    = row_q;
    col_d    = col_q;
    a_d      = a_q;
    b_d      = b_q;
    tgt_d    = tgt_q;
    busy_d   = busy_q;
    wr_d     = 1'b0;
    dat_d    = dat_q;
    done_d   = 1'b0;
    emit_s   = 1'b0;
    char_s   = 8'h00;
    next_s   = S_IDLE;
    row_nx_s = row_q;
    col_nx_s = col_q;
    idx_s    = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          busy_d  = 1'b1;
          a_d     = bus.board_a;
          b_d     = bus.board_b;
          tgt_d   = bus.target_a;
          row_d   = '0;
          col_d   = '0;
          state_d = S_CELL;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_CELL: begin
        emit_s = 1'b1;
        char_s = cell_char(a_q[idx_s], b_q[idx_s]);
        if (col_q == COL_LAST) begin
          col_nx_s = '0;
          next_s   = S_CR;
        end else begin
          col_nx_s = col_q + COL_W'(1);
          next_s   = S_CELL;
        end
      end
      S_CR: begin
        emit_s = 1'b1;
        char_s = 8'h0D;
        next_s = S_LF;
      end
      S_LF: begin
        emit_s = 1'b1;
        char_s = 8'h0A;
        if (row_q == ROW_LAST) begin
          next_s   = S_TURN;
        end else begin
          row_nx_s = row_q + ROW_W'(1);
          next_s   = S_CELL;
        end
      end
      S_TURN: begin
        emit_s = 1'b1;
        char_s = tgt_q ? 8'h58 : 8'h4F;
        next_s = S_PROMPT;
      end
      S_PROMPT: begin
        // No trailing newline: the receiver's '?' continues on this line.
        emit_s = 1'b1;
        char_s = 8'h3E;
        next_s = S_DONE;
      end
      S_GAP: begin
        state_d = ret_q;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b1;
      end
    endcase

    // Byte-emitting states only advance (counters included) when the UART accepts.
    if (emit_s && bus.uart_ready) begin
      wr_d    = 1'b1;
      dat_d   = char_s;
      ret_d   = next_s;
      row_d   = row_nx_s;
      col_d   = col_nx_s;
      state_d = S_GAP;
    end else begin
      wr_d    = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tgt_q   <= 1'b0;
      busy_q  <= 1'b1;
      wr_q    <= 1'b0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready   = ~bus.req & ~busy_q;
  assign bus.done    = done_q;
  assign bus.uart_wr = wr_q;
  assign bus.uart_d  = dat_q;

endmodule

// File: tb/tb_send_board.sv
// Randomized bench for send_board: a frame-level text model predicts every byte,
// and one negedge monitor checks strobes, spacing, timing and done against it.
module tb_send_board;

  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int CELLS = ROWS * COLS;
  localparam int N     = ROWS * (COLS + 2) + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  send_board_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  send_board #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   k_accept = 0;
  int   byte_idx = 0;
  int   done_cnt = 0;
  logic ur_edge = 1'b1;
  logic rst_edge = 1'b1;
  logic prev_wr = 1'b0;
  logic frame_active = 1'b0;
  logic check_timing = 1'b0;
  logic ur_random = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Text frame the board must render as: one row per line, then turn letter and '>'.
  task automatic build_model(input logic [CELLS-1:0] a, input logic [CELLS-1:0] b, input logic t);
    model_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int idx;
        idx = r * COLS + c;
        if (a[idx] && b[idx])      model_q.push_back(8'h23);
        else if (a[idx])           model_q.push_back(8'h58);
        else if (b[idx])           model_q.push_back(8'h4F);
        else                       model_q.push_back(8'h2E);
      end
      model_q.push_back(8'h0D);
      model_q.push_back(8'h0A);
    end
    model_q.push_back(t ? 8'h58 : 8'h4F);
    model_q.push_back(8'h3E);
  endtask

  task automatic check_literal(input string nm, input logic [7:0] q[$], input string s);
    chk({nm, "_len"}, q.size(), s.len());
    for (int i = 0; i < s.len() && i < q.size(); i++) begin
      chk(nm, q[i], s[i]);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    ur_edge  = bus.uart_ready;
    rst_edge = reset;
  end

  always @(posedge clk) begin
    #1;
    bus.uart_ready = ur_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Per-cycle output checker.
  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_uart_wr", bus.uart_wr, 0);
      chk("rst_uart_d", bus.uart_d, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ready", bus.ready, 0);
    end else begin
      if (bus.uart_wr) begin
        chk("strobe_spacing", prev_wr, 0);
        chk("strobe_uart_ready", ur_edge, 1);
        chk("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte", bus.uart_d, exp_q.pop_front());
        got_q.push_back(bus.uart_d);
        if (check_timing) chk("strobe_time", cyc - k_accept, 1 + 2 * byte_idx);
        byte_idx++;
      end
      if (bus.done) begin
        chk("done_expected", frame_active, 1);
        chk("done_after_last", exp_q.size(), 0);
        if (check_timing) chk("done_time", cyc - k_accept, 2 * N + 1);
        frame_active = 1'b0;
        done_cnt++;
      end
    end
    prev_wr = bus.uart_wr;
  end

  task automatic start_frame(input logic [CELLS-1:0] a, input logic [CELLS-1:0] b, input logic t);
    for (int i = 0; i < 200 && !bus.ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_req", bus.ready, 1);
    bus.board_a  = a;
    bus.board_b  = b;
    bus.target_a = t;
    bus.req      = 1'b1;
    build_model(a, b, t);
    exp_q = model_q;
    got_q.delete();
    byte_idx     = 0;
    frame_active = 1'b1;
    @(posedge clk); #1;
    k_accept = cyc;
    bus.req  = 1'b0;
  endtask

  task automatic finish_frame();
    int start;
    int i;
    start = done_cnt;
    i = 0;
    while (done_cnt == start && i < 3000) begin
      @(negedge clk); #1;
      i++;
    end
    chk("done_seen", done_cnt - start, 1);
    @(negedge clk); #1;
    chk("ready_after_done", bus.ready, 1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    chk("single_done", done_cnt - start, 1);
    chk("frame_len", got_q.size(), N);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 1000 && byte_idx < n; i++) begin
      @(negedge clk); #1;
    end
    chk("bytes_reached", byte_idx, n);
  endtask

  string lit_empty = "...\015\012...\015\012...\015\012X>";
  string lit_mix   = "XO.\015\012.X.\015\012..O\015\012O>";

  initial begin
    logic [CELLS-1:0] ra;
    logic [CELLS-1:0] rb;
    logic             rt;
    int               start;

    bus.req        = 1'b0;
    bus.target_a   = 1'b0;
    bus.board_a    = '0;
    bus.board_b    = '0;
    bus.uart_ready = 1'b1;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("ready_release_c1", bus.ready, 0);
    @(negedge clk); #1;
    chk("ready_release_c2", bus.ready, 1);

    // Empty board, A to move, UART always ready: exact cycle timing checked.
    build_model('0, '0, 1'b1);
    check_literal("model_empty", model_q, lit_empty);
    check_timing = 1'b1;
    start_frame('0, '0, 1'b1);
    finish_frame();
    check_literal("frame_empty", got_q, lit_empty);

    // Mixed board, B to move.
    build_model(9'b000_010_001, 9'b100_000_010, 1'b0);
    check_literal("model_mix", model_q, lit_mix);
    start_frame(9'b000_010_001, 9'b100_000_010, 1'b0);
    finish_frame();
    check_literal("frame_mix", got_q, lit_mix);

    // Same request with a randomly stalling UART.
    check_timing = 1'b0;
    ur_random    = 1'b1;
    start_frame(9'b000_010_001, 9'b100_000_010, 1'b0);
    finish_frame();
    check_literal("frame_mix_stall", got_q, lit_mix);

    // Centre cell claimed by both players.
    rt = 1'($urandom_range(0, 1));
    start_frame(9'b000_010_000, 9'b000_010_000, rt);
    finish_frame();
    chk("corrupt_cell4", (got_q.size() > 6) ? got_q[6] : 8'h00, 8'h23);

    // Reset after the sixth byte abandons the frame.
    ur_random = 1'b0;
    start_frame(CELLS'($urandom()), CELLS'($urandom()), 1'($urandom_range(0, 1)));
    wait_bytes(6);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    frame_active = 1'b0;
    start = done_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst_c1", bus.ready, 0);
    @(negedge clk); #1;
    chk("ready_after_rst_c2", bus.ready, 1);
    repeat (10) begin
      @(negedge clk); #1;
    end
    chk("no_done_after_rst", done_cnt - start, 0);
    chk("no_bytes_after_rst", got_q.size(), 6);
    check_timing = 1'b1;
    start_frame(9'b000_010_001, 9'b100_000_010, 1'b0);
    finish_frame();
    check_literal("frame_after_rst", got_q, lit_mix);

    // Repeated req and changing inputs mid-transfer must not disturb the snapshot.
    check_timing = 1'b0;
    ur_random    = 1'b1;
    ra = CELLS'($urandom());
    rb = CELLS'($urandom());
    rt = 1'($urandom_range(0, 1));
    start_frame(ra, rb, rt);
    wait_bytes(4);
    @(posedge clk); #1;
    bus.req      = 1'b1;
    bus.board_a  = ~ra;
    bus.board_b  = CELLS'($urandom());
    bus.target_a = ~rt;
    @(posedge clk); #1;
    bus.req = 1'b0;
    finish_frame();

    // Random boards with random UART readiness.
    for (int n = 0; n < 8; n++) begin
      ur_random    = 1'($urandom_range(0, 1));
      check_timing = ~ur_random;
      start_frame(CELLS'($urandom()), CELLS'($urandom()), 1'($urandom_range(0, 1)));
      finish_frame();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
